// File: rtl/pipelined_array_mult_if.sv
// Operand/result port bundle for pipelined_array_mult.
// Both sides use valid/ready. A transfer happens on a rising edge where valid && ready are both 1.
// The source holds its payload stable while valid && !ready. Ready never depends on valid.
interface pipelined_array_mult_if #(
  parameter int WIDTH = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_m;
  logic [WIDTH-1:0]   in_q;
  logic               in_signed;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] out_p;

  modport master (
    output in_valid, in_m, in_q, in_signed, out_ready,
    input  in_ready, out_valid, out_p
  );

  modport slave (
    input  in_valid, in_m, in_q, in_signed, out_ready,
    output in_ready, out_valid, out_p
  );
endinterface

// File: rtl/pipelined_array_mult.sv
// WIDTH-stage pipelined array multiplier, unsigned or two's-complement per transaction.
// Stage k adds partial-product row k-1; the last stage is the output register.
module pipelined_array_mult #(
  parameter int WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  pipelined_array_mult_if.slave bus,
  output logic                  busy
);
  localparam int PW = 2 * WIDTH;

  logic [WIDTH-1:0] vld;
  logic [PW-1:0]    sum_r [WIDTH];
  // Operands only need to travel through the stages that still have rows to add.
  logic [WIDTH-1:0] m_r   [WIDTH-1];
  logic [WIDTH-1:0] q_r   [WIDTH-1];
  logic [WIDTH-2:0] sgn_r;
  logic             advance;

  function automatic logic [PW-1:0] pp_row(input logic [WIDTH-1:0] m,
                                           input logic             q_bit,
                                           input logic             s,
                                           input int               k);
    logic [PW-1:0] ext;
    logic [PW-1:0] row;
    ext = s ? {{WIDTH{m[WIDTH-1]}}, m} : {{WIDTH{1'b0}}, m};
    row = q_bit ? (ext << k) : '0;
    // The multiplier MSB carries negative weight in two's complement.
    if (s && (k == WIDTH - 1)) row = '0 - row;
    return row;
  endfunction

  assign advance       = !vld[WIDTH-1] || bus.out_ready;
  assign bus.in_ready  = advance;
  assign bus.out_valid = vld[WIDTH-1];
  assign bus.out_p     = sum_r[WIDTH-1];
  assign busy          = |vld;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld   <= '0;
      sgn_r <= '0;
      for (int k = 0; k < WIDTH; k++) sum_r[k] <= '0;
      for (int k = 0; k < WIDTH - 1; k++) begin
        m_r[k] <= '0;
        q_r[k] <= '0;
      end
    end else if (advance) begin
      vld      <= {vld[WIDTH-2:0], bus.in_valid};
      sum_r[0] <= pp_row(bus.in_m, bus.in_q[0], bus.in_signed, 0);
      m_r[0]   <= bus.in_m;
      q_r[0]   <= bus.in_q;
      sgn_r[0] <= bus.in_signed;
      for (int k = 1; k < WIDTH; k++)
        sum_r[k] <= sum_r[k-1] + pp_row(m_r[k-1], q_r[k-1][k], sgn_r[k-1], k);
      for (int k = 1; k < WIDTH - 1; k++) begin
        m_r[k]   <= m_r[k-1];
        q_r[k]   <= q_r[k-1];
        sgn_r[k] <= sgn_r[k-1];
      end
    end
  end
endmodule

// File: tb/tb_pipelined_array_mult.sv
// Bench for pipelined_array_mult: a WIDTH=4 and a WIDTH=8 instance share one clock and reset,
// each checked every cycle against a transaction-queue model of the pipeline.
module tb_pipelined_array_mult;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  logic        drv_valid [2];
  logic        drv_s     [2];
  logic        drv_ready [2];
  logic [15:0] drv_m     [2];
  logic [15:0] drv_q     [2];
  logic        ov [2];
  logic        ir [2];
  logic        bz [2];
  logic [15:0] op [2];
  logic        busy4, busy8;

  typedef struct {
    logic [15:0] p;
    int          age;
  } item_t;
  item_t mq0[$];
  item_t mq1[$];

  pipelined_array_mult_if #(.WIDTH(4)) b4 ();
  pipelined_array_mult_if #(.WIDTH(8)) b8 ();

  pipelined_array_mult #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(b4), .busy(busy4));
  pipelined_array_mult #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(b8), .busy(busy8));

  assign b4.in_valid  = drv_valid[0];
  assign b4.in_m      = drv_m[0][3:0];
  assign b4.in_q      = drv_q[0][3:0];
  assign b4.in_signed = drv_s[0];
  assign b4.out_ready = drv_ready[0];
  assign b8.in_valid  = drv_valid[1];
  assign b8.in_m      = drv_m[1][7:0];
  assign b8.in_q      = drv_q[1][7:0];
  assign b8.in_signed = drv_s[1];
  assign b8.out_ready = drv_ready[1];

  assign ov[0] = b4.out_valid;
  assign ov[1] = b8.out_valid;
  assign ir[0] = b4.in_ready;
  assign ir[1] = b8.in_ready;
  assign op[0] = {8'h00, b4.out_p};
  assign op[1] = b8.out_p;
  assign bz[0] = busy4;
  assign bz[1] = busy8;

  // Directed WIDTH=4 vectors: {m, q, signed, product}.
  localparam logic [15:0] T4_M [8] = '{16'hF, 16'h0, 16'h1, 16'h8, 16'h8, 16'hF, 16'h7, 16'h8};
  localparam logic [15:0] T4_Q [8] = '{16'hF, 16'h9, 16'h1, 16'h8, 16'h7, 16'hF, 16'hF, 16'h8};
  localparam logic        T4_S [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  localparam logic [15:0] T4_P [8] = '{16'hE1, 16'h00, 16'h01, 16'h40, 16'hC8, 16'h01, 16'hF9, 16'h40};

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] ref_prod(input int w, input logic [15:0] m,
                                           input logic [15:0] q, input logic s);
    longint a, b, full;
    a = longint'(m) & ((longint'(1) << w) - 1);
    b = longint'(q) & ((longint'(1) << w) - 1);
    if (s && ((a >> (w - 1)) & 1) == 1) a = a - (longint'(1) << w);
    if (s && ((b >> (w - 1)) & 1) == 1) b = b - (longint'(1) << w);
    full = a * b;
    return 16'(full & ((longint'(1) << (2 * w)) - 1));
  endfunction

  // Model: in-flight transactions in acceptance order, each aged by the advancing edges it has seen.
  task automatic model_step(input int i);
    item_t mq[$];
    item_t it;
    int    w;
    logic  mv;
    w = (i == 0) ? 4 : 8;
    if (i == 0) mq = mq0; else mq = mq1;
    if (rst) begin
      mq.delete();
      chk($sformatf("i%0d_rst_out_valid", i), 16'(ov[i]), 16'd0);
      chk($sformatf("i%0d_rst_out_p", i), op[i], 16'd0);
      chk($sformatf("i%0d_rst_busy", i), 16'(bz[i]), 16'd0);
      chk($sformatf("i%0d_rst_in_ready", i), 16'(ir[i]), 16'd1);
    end else begin
      mv = (mq.size() > 0) && (mq[0].age == w - 1);
      chk($sformatf("i%0d_out_valid", i), 16'(ov[i]), 16'(mv));
      chk($sformatf("i%0d_busy", i), 16'(bz[i]), 16'(mq.size() != 0));
      chk($sformatf("i%0d_in_ready", i), 16'(ir[i]), 16'(!mv || drv_ready[i]));
      if (mv) chk($sformatf("i%0d_out_p", i), op[i], mq[0].p);
      if (!mv || drv_ready[i]) begin
        if (mv) void'(mq.pop_front());
        for (int k = 0; k < mq.size(); k++) mq[k].age = mq[k].age + 1;
        if (drv_valid[i]) begin
          it.p   = ref_prod(w, drv_m[i], drv_q[i], drv_s[i]);
          it.age = 0;
          mq.push_back(it);
        end
      end
    end
    if (i == 0) mq0 = mq; else mq1 = mq;
  endtask

  always @(negedge clk) begin
    model_step(0);
    model_step(1);
  end

  task automatic cyc(input int i, output bit acc);
    @(negedge clk);
    acc = drv_valid[i] && ir[i];
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < 2; i++) begin
      drv_valid[i] = 1'b0;
      drv_ready[i] = 1'b1;
    end
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One transaction into an empty pipeline; pins latency and the literal product.
  task automatic single(input int i, input logic [15:0] m, input logic [15:0] q,
                        input logic s, input logic [15:0] exp);
    int w;
    bit acc;
    w = (i == 0) ? 4 : 8;
    drv_valid[i] = 1'b1;
    drv_m[i] = m;
    drv_q[i] = q;
    drv_s[i] = s;
    drv_ready[i] = 1'b1;
    cyc(i, acc);
    chk($sformatf("i%0d_single_accept", i), 16'(acc), 16'd1);
    drv_valid[i] = 1'b0;
    repeat (w - 2) @(posedge clk);
    @(negedge clk);
    chk($sformatf("i%0d_single_early", i), 16'(ov[i]), 16'd0);
    @(negedge clk);
    chk($sformatf("i%0d_single_valid", i), 16'(ov[i]), 16'd1);
    chk($sformatf("i%0d_single_p_%h_%h_%0d", i, m, q, s), op[i], exp);
    @(posedge clk);
    #1;
  endtask

  task automatic stream(input int i, input int n, input int stall_from,
                        input int stall_len, input bit rnd);
    int sent, cnt, w;
    bit acc;
    sent = 0;
    cnt  = 0;
    acc  = 1'b0;
    w    = (i == 0) ? 4 : 8;
    drv_valid[i] = 1'b0;
    while (sent < n && cnt < 60000) begin
      if (!drv_valid[i] || acc) begin
        drv_valid[i] = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        drv_m[i] = 16'($urandom_range(0, (1 << w) - 1));
        drv_q[i] = 16'($urandom_range(0, (1 << w) - 1));
        drv_s[i] = 1'($urandom_range(0, 1));
      end
      drv_ready[i] = rnd ? ($urandom_range(0, 3) != 0)
                         : !(cnt >= stall_from && cnt < stall_from + stall_len);
      cyc(i, acc);
      if (acc) sent++;
      cnt++;
    end
    drv_valid[i] = 1'b0;
    drv_ready[i] = 1'b1;
    chk($sformatf("i%0d_stream_accepts", i), 16'(sent), 16'(n));
  endtask

  initial begin
    bit acc;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drv_valid[i] = 1'b0;
      drv_ready[i] = 1'b1;
      drv_m[i] = '0;
      drv_q[i] = '0;
      drv_s[i] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    for (int t = 0; t < 8; t++) single(0, T4_M[t], T4_Q[t], T4_S[t], T4_P[t]);
    single(1, 16'h80, 16'h80, 1'b1, 16'h4000);
    single(1, 16'hFF, 16'hFF, 1'b0, 16'hFE01);
    single(1, 16'hFF, 16'h02, 1'b1, 16'hFFFE);

    // Same vectors back-to-back, each following its own mode flag.
    for (int t = 0; t < 8; t++) begin
      drv_valid[0] = 1'b1;
      drv_m[0] = T4_M[t];
      drv_q[0] = T4_Q[t];
      drv_s[0] = T4_S[t];
      cyc(0, acc);
      chk("i0_b2b_accept", 16'(acc), 16'd1);
    end
    idle(10);

    stream(0, 6, 5, 3, 1'b0);
    idle(10);

    for (int t = 0; t < 4; t++) begin
      drv_valid[0] = (t % 2 == 0);
      drv_m[0] = 16'($urandom_range(0, 15));
      drv_q[0] = 16'($urandom_range(0, 15));
      drv_s[0] = 1'($urandom_range(0, 1));
      cyc(0, acc);
    end
    drv_valid[0] = 1'b0;
    idle(8);
    chk("i0_bubbles_busy_idle", 16'(bz[0]), 16'd0);

    stream(0, 5, 1000, 0, 1'b0);
    rst = 1'b1;
    #1;
    chk("i0_midrst_out_valid", 16'(ov[0]), 16'd0);
    chk("i0_midrst_out_p", op[0], 16'd0);
    chk("i0_midrst_busy", 16'(bz[0]), 16'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(12);

    fork
      stream(0, 3000, 0, 0, 1'b1);
      stream(1, 10000, 0, 0, 1'b1);
    join
    idle(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule

// File: doc/pipelined_array_mult.md
# pipelined_array_mult

- Parametrised, pipelined successor to the team's combinational 4x4 array multiplier.
- Multiplies two WIDTH-bit operands, unsigned or two's-complement, selected per transaction, and produces a full 2*WIDTH-bit product.
- The partial-product array has one registered row per multiplier bit, giving one result per clock sustained.
- Sits between an operand source and a result sink; both sides use valid/ready handshakes with full backpressure.

## Interface

Parameters:
- WIDTH, 4, operand width in bits; legal range 2..16. Pipeline depth equals WIDTH.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand source presents a transaction.
- in_ready  output  1  the block can accept a transaction this cycle.
- in_m  input  WIDTH  multiplicand.
- in_q  input  WIDTH  multiplier.
- in_signed  input  1  1 = two's-complement operands, 0 = unsigned; captured with the operands.
- out_valid  output  1  out_p holds a completed product.
- out_ready  input  1  result sink accepts out_p this cycle.
- out_p  output  2*WIDTH  product.
- busy  output  1  at least one stage holds a valid transaction.

## Operation

- Pipeline stages S1..S_WIDTH. Each stage holds:
  - valid bit
  - m, q, signed flag
  - running partial sum, 2*WIDTH bits
- Stage k adds partial-product row k-1 (in_m AND in_q[k-1], shifted left by k-1) to the sum from stage k-1. S1 starts from zero.
- S_WIDTH is the output register: out_valid = S_WIDTH.valid and out_p = S_WIDTH.sum.
- Signed mode:
  - out_p equals the exact two's-complement product of sign-extended operands, truncated to 2*WIDTH bits. This is always exact at that width.
  - The row for the multiplier MSB is subtracted rather than added, and the multiplicand is sign-extended in every row.
  - Any internal construction giving identical results is acceptable.
- Unsigned mode: out_p = in_m * in_q.
- Advance rule: advance = !out_valid || out_ready.
  - When advance = 1, every stage loads from its predecessor on the edge.
  - S1 loads the input transaction when in_valid && in_ready, otherwise it loads a bubble (valid = 0).
  - When advance = 0, all stages hold, including bubbles. There is no internal compaction.
- in_ready = advance. This is a combinational path from out_ready and out_valid only. It must not depend on in_valid.
- Transaction transfer occurs on an edge where in_valid && in_ready. Output transfer occurs on an edge where out_valid && out_ready.
- busy = OR of all stage valid bits.
- Transactions leave in the same order they are accepted. None is dropped or duplicated under any in_valid/out_ready pattern.
- Datapath contents of invalid stages are don't-care internally.
- out_p is always the S_WIDTH sum register, even when out_valid = 0. After reset that register reads 0.

## Timing

- Reset, asynchronous on rst high:
  - All valid bits clear.
  - out_valid = 0, out_p = 0, busy = 0.
  - in_ready = 1 while rst is high and after release.
  - The first edge with rst low may accept a transaction.
- Reset mid-operation discards all in-flight transactions; no result for them ever appears.
- Latency: a transaction accepted on edge E shows out_valid = 1 after edge E + WIDTH - 1 if no stall intervenes. With WIDTH = 4, acceptance at edge 0 gives the result after edge 3.
- Each stalled cycle (out_valid && !out_ready) adds one cycle of latency to every in-flight transaction.
- Throughput: one accept and one result per cycle when out_ready is held high.
- Simultaneous output transfer and input accept on the same edge is legal and required; the pipeline stays full.
- While stalled:
  - out_p and out_valid are stable.
  - in_ready = 0, so in_m, in_q and in_signed are ignored.

## Test plan

- Unsigned, WIDTH = 4, out_ready = 1:
  - 15*15 -> 0xE1
  - 0*9 -> 0x00
  - 1*1 -> 0x01
  - Each result appears exactly 3 edges after acceptance.
- Signed, WIDTH = 4:
  - -8*-8 -> 0x40
  - -8*7 -> 0xC8
  - -1*-1 -> 0x01
  - 7*-1 -> 0xF9
  - Mixed with unsigned 8*8 -> 0x40 back-to-back, so each result follows its own mode flag.
- Backpressure:
  - Stream 6 transactions on consecutive cycles, with out_ready low for 3 cycles mid-stream.
  - Required: in_ready low during the stall, out_p stable, all 6 results in order, none lost.
- Bubbles: in_valid toggled 1,0,1,0 with out_ready = 1 -> out_valid shows the same 1,0,1,0 pattern shifted by 3 cycles. busy drops to 0 after the last result.
- Reset mid-flight: accept 3 transactions, assert rst for 1 cycle -> out_valid = 0, out_p = 0, busy = 0 immediately; no stale result appears afterward.
- WIDTH = 8: random 10k signed and unsigned pairs under random in_valid/out_ready checked against a reference model, e.g. -128*-128 -> 0x4000 and 255*255 -> 0xFE01. Latency is 7 edges with no stalls.
